// File: rtl/pdm_pkg.sv
// Shared constants and arithmetic helpers for the PDM audio path.
package pdm_pkg;

  localparam int PCM_W_DEF    = 16;
  localparam int LOG2_OSR_DEF = 7;
  localparam int INT_GUARD    = 4;
  localparam int SAT_W        = 32;

  typedef logic signed [SAT_W-1:0] sat_t;

  function automatic int int_width(input int w);
    return w + INT_GUARD;
  endfunction

  function automatic sat_t full_scale(input int w);
    return sat_t'(1) <<< (w - 1);
  endfunction

  function automatic sat_t int_limit(input int w);
    return (sat_t'(1) <<< (w + 2)) - sat_t'(1);
  endfunction

  // Add with a one-bit guard so the clamp sees the true sum, then limit to +/-lim.
  function automatic sat_t sat_add(input sat_t a, input sat_t b, input sat_t lim);
    logic signed [SAT_W:0] s;
    logic signed [SAT_W:0] hi;
    s  = {a[SAT_W-1], a} + {b[SAT_W-1], b};
    hi = {lim[SAT_W-1], lim};
    if (s > hi)       return lim;
    else if (s < -hi) return -lim;
    else              return s[SAT_W-1:0];
  endfunction

endpackage

// File: rtl/pdm_mod2.sv
// Second-order 1-bit delta-sigma modulator with saturating integrators.
module pdm_mod2
  import pdm_pkg::*;
#(
  parameter int W = PCM_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_en,
  input  logic signed [W-1:0] i_x,
  output logic                o_pdm
);

  localparam int   IW  = int_width(W);
  localparam sat_t FS  = full_scale(W);
  localparam sat_t LIM = int_limit(W);

  logic signed [IW-1:0] r_i1;
  logic signed [IW-1:0] r_i2;
  logic                 r_pdm;

  sat_t w_fb;
  sat_t w_x;
  sat_t w_i1_new;
  sat_t w_i2_new;

  always_comb begin
    w_fb     = r_pdm ? FS : -FS;
    w_x      = sat_t'(i_x);
    w_i1_new = sat_add(sat_t'(r_i1), w_x - w_fb, LIM);
    w_i2_new = sat_add(sat_t'(r_i2), w_i1_new - w_fb, LIM);
  end

  // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_i1  <= '0;
      r_i2  <= '0;
      r_pdm <= 1'b0;
    end else if (i_en) begin
      r_i1  <= IW'(w_i1_new);
      r_i2  <= IW'(w_i2_new);
      r_pdm <= ~w_i2_new[SAT_W-1];
    end
  end

  assign o_pdm = r_pdm;

endmodule

// File: rtl/pdm_tx.sv
// PDM transmitter: 2-entry PCM buffer, linear interpolator to the bit rate, mod2 noise shaper.
module pdm_tx
  import pdm_pkg::*;
#(
  parameter int W        = PCM_W_DEF,
  parameter int LOG2_OSR = LOG2_OSR_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en_sample,
  input  logic                en_pcm,
  input  logic signed [W-1:0] pcm_in,
  input  logic                pcm_valid,
  output logic                pcm_ready,
  output logic                pdm_out,
  output logic                underrun,
  input  logic                underrun_clr
);

  localparam int AW = W + LOG2_OSR;

  logic signed [W-1:0]  r_mem [2];
  logic                 r_wr_ptr;
  logic                 r_rd_ptr;
  logic [1:0]           r_count;
  logic [1:0]           w_count_nxt;
  logic                 r_ready;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_empty;
  logic signed [W-1:0]  w_head;

  logic signed [W-1:0]  r_prev;
  logic signed [W-1:0]  r_cur;
  logic signed [W:0]    r_step;
  logic signed [AW-1:0] r_acc;
  logic signed [W-1:0]  w_x;
  logic                 r_underrun;
  logic                 w_unused_prev;

  assign w_empty = (r_count == 2'd0);
  assign w_push  = pcm_valid && r_ready;
  assign w_pop   = en_pcm && !w_empty;
  assign w_head  = r_mem[r_rd_ptr];

  // NOTE: the default assignment first keeps this always_comb free of inferred latches.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 2'd1;
      2'b01:   w_count_nxt = r_count - 2'd1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
      r_ready  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      r_count <= w_count_nxt;
      r_ready <= (w_count_nxt != 2'd2);
    end
  end

  // NOTE: storage needs no reset; the count decides what is valid, so a reset simply discards it.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= pcm_in;
  end

  // A frame load restarts the ramp from the old sample; an empty buffer holds the level flat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= '0;
      r_cur  <= '0;
      r_step <= '0;
      r_acc  <= '0;
    end else if (en_pcm) begin
      r_prev <= r_cur;
      r_acc  <= {r_cur, {LOG2_OSR{1'b0}}};
      if (w_pop) begin
        r_cur  <= w_head;
        r_step <= {w_head[W-1], w_head} - {r_cur[W-1], r_cur};
      end else begin
        r_step <= '0;
      end
    end else if (en_sample) begin
      r_acc <= r_acc + {{(LOG2_OSR-1){r_step[W]}}, r_step};
    end
  end

  assign w_x = r_acc[AW-1:LOG2_OSR];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r_underrun <= 1'b0;
    else if (en_pcm && w_empty)  r_underrun <= 1'b1;
    else if (underrun_clr)       r_underrun <= 1'b0;
  end

  // Frame history kept for a future higher-order interpolator; nothing consumes it yet.
  assign w_unused_prev = ^r_prev;

  pdm_mod2 #(.W(W)) u_mod (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (en_sample),
    .i_x   (w_x),
    .o_pdm (pdm_out)
  );

  assign pcm_ready = r_ready;
  assign underrun  = r_underrun;

endmodule

// File: tb/tb_pdm_tx.sv
// Self-checking bench for pdm_tx against a behavioural frame/ramp/modulator model.
module tb_pdm_tx;

  localparam int L   = 7;
  localparam int OSR = 128;
  localparam int FS  = 32768;
  localparam int LIM = 262143;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en_sample;
  logic        en_pcm;
  logic [15:0] pcm_in;
  logic        pcm_valid;
  logic        pcm_ready;
  logic        pdm_out;
  logic        underrun;
  logic        underrun_clr;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: queue for the buffer, ramp endpoints plus step count for the interpolator.
  int mq[$];
  int m_cur, m_base, m_tgt, m_k, m_i1, m_i2;
  bit m_pdm, m_ready, m_und;

  always #5 clk = ~clk;

  pdm_tx dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en_sample    (en_sample),
    .en_pcm       (en_pcm),
    .pcm_in       (pcm_in),
    .pcm_valid    (pcm_valid),
    .pcm_ready    (pcm_ready),
    .pdm_out      (pdm_out),
    .underrun     (underrun),
    .underrun_clr (underrun_clr)
  );

  function automatic int clamp(input int v);
    if (v > LIM)  return LIM;
    if (v < -LIM) return -LIM;
    return v;
  endfunction

  function automatic int model_x();
    return (m_base * OSR + m_k * (m_tgt - m_base)) >>> L;
  endfunction

  function automatic int dut_x();
    logic signed [15:0] t;
    t = dut.w_x;
    return int'(t);
  endfunction

  function automatic int dut_cur();
    logic signed [15:0] t;
    t = dut.r_cur;
    return int'(t);
  endfunction

  function automatic int cyc_mism();
    int m = 0;
    if (pdm_out !== m_pdm)     m++;
    if (pcm_ready !== m_ready) m++;
    if (underrun !== m_und)    m++;
    if (dut_x() != model_x())  m++;
    return m;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_cur = 0; m_base = 0; m_tgt = 0; m_k = 0;
    m_i1 = 0; m_i2 = 0; m_pdm = 0; m_ready = 1; m_und = 0;
  endtask

  // One clock: drive inputs, advance the model, then sample the DUT 1 ns after the edge.
  task automatic cyc(input bit es, input bit ep, input bit v, input int d, input bit clr);
    int  xo, fb, popped;
    bit  had, push;
    en_sample    = es;
    en_pcm       = ep;
    pcm_valid    = v;
    pcm_in       = d[15:0];
    underrun_clr = clr;
    xo   = model_x();
    had  = (mq.size() != 0);
    push = v && m_ready;
    if (ep) begin
      m_base = m_cur;
      if (had) begin
        popped = mq.pop_front();
        m_cur  = popped;
      end
      m_tgt = m_cur;
      m_k   = 0;
    end else if (es) begin
      m_k++;
    end
    if (ep && !had) m_und = 1;
    else if (clr)   m_und = 0;
    if (push) mq.push_back(d);
    m_ready = (mq.size() != 2);
    if (es) begin
      fb    = m_pdm ? FS : -FS;
      m_i1  = clamp(m_i1 + xo - fb);
      m_i2  = clamp(m_i2 + m_i1 - fb);
      m_pdm = (m_i2 >= 0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input int val, output int ones, output int mism);
    ones = 0;
    mism = 0;
    for (int i = 0; i < OSR; i++) begin
      cyc(1'b1, i == 0, 1'b1, val, 1'b0);
      ones += int'(pdm_out);
      mism += cyc_mism();
    end
  endtask

  task automatic test_reset();
    n_total++; if (pdm_out !== 1'b0)   begin n_bad++; $display("FAIL rst_pdm got=%b want=0", pdm_out); end
    n_total++; if (underrun !== 1'b0)  begin n_bad++; $display("FAIL rst_underrun got=%b want=0", underrun); end
    n_total++; if (pcm_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready got=%b want=1", pcm_ready); end
  endtask

  task automatic test_ramp();
    int wrong = 0;
    cyc(1'b0, 1'b0, 1'b1, 1280, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 0, 1'b0);
    n_total++; if (dut_x() != 0) begin n_bad++; $display("FAIL ramp_load_no_add got=%0d want=0", dut_x()); end
    for (int k = 1; k <= OSR; k++) begin
      cyc(1'b1, 1'b0, 1'b0, 0, 1'b0);
      if (dut_x() != 10 * k || cyc_mism() != 0) wrong++;
    end
    n_total++; if (wrong != 0) begin n_bad++; $display("FAIL ramp_steps got=%0d bad steps want=0", wrong); end
    n_total++; if (dut_x() != 1280) begin n_bad++; $display("FAIL ramp_end got=%0d want=1280", dut_x()); end
  endtask

  task automatic test_backpressure();
    cyc(1'b0, 1'b0, 1'b1, 111, 1'b0);
    n_total++; if (pcm_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready1 got=%b want=1", pcm_ready); end
    cyc(1'b0, 1'b0, 1'b1, -222, 1'b0);
    n_total++; if (pcm_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready2 got=%b want=0", pcm_ready); end
    cyc(1'b0, 1'b0, 1'b1, 333, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 333, 1'b0);
    n_total++; if (pcm_ready !== 1'b0) begin n_bad++; $display("FAIL bp_held got=%b want=0", pcm_ready); end
    cyc(1'b0, 1'b1, 1'b1, 333, 1'b0);
    n_total++; if (dut_cur() != 111) begin n_bad++; $display("FAIL bp_pop1 got=%0d want=111", dut_cur()); end
    n_total++; if (pcm_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_after_pop got=%b want=1", pcm_ready); end
    cyc(1'b0, 1'b0, 1'b1, 333, 1'b0);
    n_total++; if (pcm_ready !== 1'b0) begin n_bad++; $display("FAIL bp_third_taken got=%b want=0", pcm_ready); end
    cyc(1'b0, 1'b0, 1'b0, 0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 0, 1'b0);
    n_total++; if (dut_cur() != -222) begin n_bad++; $display("FAIL bp_pop2 got=%0d want=-222", dut_cur()); end
    cyc(1'b0, 1'b1, 1'b0, 0, 1'b0);
    n_total++; if (dut_cur() != 333) begin n_bad++; $display("FAIL bp_pop3 got=%0d want=333", dut_cur()); end
    n_total++; if (underrun !== 1'b0) begin n_bad++; $display("FAIL bp_no_underrun got=%b want=0", underrun); end
  endtask

  task automatic test_underrun();
    cyc(1'b0, 1'b1, 1'b0, 0, 1'b0);
    n_total++; if (underrun !== 1'b1) begin n_bad++; $display("FAIL ur_set got=%b want=1", underrun); end
    n_total++; if (dut_cur() != 333) begin n_bad++; $display("FAIL ur_cur_held got=%0d want=333", dut_cur()); end
    n_total++; if (dut_x() != 333) begin n_bad++; $display("FAIL ur_x_flat got=%0d want=333", dut_x()); end
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 0, 1'b0);
    n_total++; if (underrun !== 1'b1) begin n_bad++; $display("FAIL ur_sticky got=%b want=1", underrun); end
    cyc(1'b0, 1'b0, 1'b0, 0, 1'b1);
    n_total++; if (underrun !== 1'b0) begin n_bad++; $display("FAIL ur_clear got=%b want=0", underrun); end
    cyc(1'b0, 1'b1, 1'b0, 0, 1'b1);
    n_total++; if (underrun !== 1'b1) begin n_bad++; $display("FAIL ur_set_wins got=%b want=1", underrun); end
    cyc(1'b0, 1'b0, 1'b0, 0, 1'b1);
    n_total++; if (underrun !== 1'b0) begin n_bad++; $display("FAIL ur_clear2 got=%b want=0", underrun); end
  endtask

  task automatic test_level(input string name, input int val, input int nframes, input int want);
    int ones, mism;
    cyc(1'b0, 1'b0, 1'b1, val, 1'b0);
    for (int f = 0; f < nframes; f++) begin
      run_frame(val, ones, mism);
      n_total++;
      if (mism != 0) begin n_bad++; $display("FAIL %s_model frame=%0d got=%0d mismatches want=0", name, f, mism); end
    end
    n_total++;
    if (ones < want - 2 || ones > want + 2) begin
      n_bad++; $display("FAIL %s_density got=%0d ones want=%0d+-2", name, ones, want);
    end
  endtask

  task automatic test_reset_midstream();
    int i;
    for (i = 0; i < 300 && !(pdm_out === 1'b1 && pcm_ready === 1'b0); i++)
      cyc(1'b1, 1'b0, 1'b1, -24576, 1'b0);
    n_total++;
    if (!(pdm_out === 1'b1 && pcm_ready === 1'b0)) begin
      n_bad++; $display("FAIL midrst_setup got pdm=%b ready=%b want pdm=1 ready=0", pdm_out, pcm_ready);
    end
    #3;
    rst_n = 1'b0;
    en_sample = 0; en_pcm = 0; pcm_valid = 0; underrun_clr = 0;
    #1;
    n_total++; if (pdm_out !== 1'b0)   begin n_bad++; $display("FAIL midrst_pdm got=%b want=0", pdm_out); end
    n_total++; if (underrun !== 1'b0)  begin n_bad++; $display("FAIL midrst_underrun got=%b want=0", underrun); end
    n_total++; if (pcm_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_ready got=%b want=1", pcm_ready); end
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 0, 1'b0);
    n_total++; if (dut_x() != 0 || dut_cur() != 0) begin
      n_bad++; $display("FAIL midrst_state got x=%0d cur=%0d want 0 0", dut_x(), dut_cur());
    end
  endtask

  task automatic test_random();
    int cnt = 0, mism = 0, frames = 0, d;
    bit es, ep, v, clr;
    logic [15:0] r16;
    for (int c = 0; c < 4000 && frames < 20; c++) begin
      es = ($urandom % 4) != 0;
      ep = (cnt == OSR);
      if (ep) cnt = 0;
      else if (es) cnt++;
      v   = $urandom % 2;
      clr = ($urandom % 64) == 0;
      r16 = 16'($urandom);
      d   = ($urandom % 5 == 0) ? int'($signed(r16)) : int'($urandom_range(0, 49152)) - 24576;
      cyc(es, ep, v, d, clr);
      mism += cyc_mism();
      if (ep) begin
        frames++;
        n_total++;
        if (mism != 0) begin n_bad++; $display("FAIL rand_frame=%0d got=%0d mismatches want=0", frames, mism); end
        mism = 0;
      end
    end
    n_total++;
    if (frames != 20) begin n_bad++; $display("FAIL rand_budget got=%0d frames want=20", frames); end
  endtask

  initial begin
    rst_n = 1'b0;
    en_sample = 0; en_pcm = 0; pcm_valid = 0; pcm_in = '0; underrun_clr = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 0, 1'b0);
    test_ramp();
    test_backpressure();
    test_underrun();
    test_level("zero", 0, 5, 64);
    test_level("dc_pos", 24576, 6, 112);
    test_level("dc_neg", -24576, 6, 16);
    test_reset_midstream();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
